// File: rtl/ex_flag_unit.sv
// ex_flag_unit: execute-stage flag register, EX/MEM result register and
// branch condition evaluation with optional same-cycle flag bypass.
module ex_flag_unit #(
  parameter int unsigned WIDTH       = 16,
  parameter bit          FLAG_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [2:0]       alu_flag,
  input  logic [2:0]       alu_op,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic             br_en,
  input  logic [2:0]       br_cond,
  output logic [2:0]       flag_q,
  output logic [WIDTH-1:0] mem_alu_out,
  output logic             mem_valid,
  output logic             br_taken
);

  localparam int unsigned FLAG_W = 3;

  // Flag bit positions within {N,Z,V}
  localparam int unsigned FN = 2;
  localparam int unsigned FZ = 1;
  localparam int unsigned FV = 0;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_RED    = 3'b010;
  localparam logic [2:0] OP_XOR    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  localparam logic [2:0] BC_NE = 3'b000;
  localparam logic [2:0] BC_EQ = 3'b001;
  localparam logic [2:0] BC_GT = 3'b010;
  localparam logic [2:0] BC_LT = 3'b011;
  localparam logic [2:0] BC_GE = 3'b100;
  localparam logic [2:0] BC_LE = 3'b101;
  localparam logic [2:0] BC_OV = 3'b110;
  localparam logic [2:0] BC_AL = 3'b111;

  logic [FLAG_W-1:0] r_flag;
  logic [WIDTH-1:0]  r_mem_alu_out;
  logic              r_mem_valid;

  logic              w_commit;
  logic [FLAG_W-1:0] w_flag_nxt;
  logic [FLAG_W-1:0] w_eff_flag;
  logic              w_cond;

  assign w_commit = ex_valid & ~stall & ~flush;

  // Next flag value: per-opcode update on commit, otherwise hold
  always_comb begin
    w_flag_nxt = r_flag;
    if (w_commit) begin
      case (alu_op)
        OP_ADD, OP_SUB: w_flag_nxt = alu_flag;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: w_flag_nxt[FZ] = (alu_out == '0);
        OP_RED, OP_PADDSB: w_flag_nxt = r_flag;
        default: w_flag_nxt = r_flag;
      endcase
    end
  end

  // Architectural flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag <= '0;
    end else begin
      r_flag <= w_flag_nxt;
    end
  end

  // EX/MEM pipeline register; flush kills valid, result is simply held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_alu_out <= '0;
      r_mem_valid   <= 1'b0;
    end else if (flush) begin
      r_mem_valid   <= 1'b0;
    end else if (!stall) begin
      r_mem_alu_out <= alu_out;
      r_mem_valid   <= ex_valid;
    end
  end

  // Branch sees either the flags being written this cycle or the stored ones
  assign w_eff_flag = FLAG_BYPASS ? w_flag_nxt : r_flag;

  // Branch condition decode against the effective flags
  always_comb begin
    w_cond = 1'b0;
    case (br_cond)
      BC_NE:   w_cond = ~w_eff_flag[FZ];
      BC_EQ:   w_cond =  w_eff_flag[FZ];
      BC_GT:   w_cond = ~w_eff_flag[FZ] & ~w_eff_flag[FN];
      BC_LT:   w_cond =  w_eff_flag[FN];
      BC_GE:   w_cond =  w_eff_flag[FZ] | ~w_eff_flag[FN];
      BC_LE:   w_cond =  w_eff_flag[FN] |  w_eff_flag[FZ];
      BC_OV:   w_cond =  w_eff_flag[FV];
      BC_AL:   w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign br_taken    = br_en & ~stall & w_cond;
  assign flag_q      = r_flag;
  assign mem_alu_out = r_mem_alu_out;
  assign mem_valid   = r_mem_valid;

endmodule
